// File: rtl/acc_psw_unit.sv
// acc_psw_unit: architectural ACC / B / PSW register stage behind the ALU.
//   Captures ALU result and flags under decoder control and supports direct
//   PSW writes. Derives parity from ACC. Runs MUL AB (shift-add) and DIV AB
//   (restoring) as iterative MD_STEPS-step sequencers.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   alu_result/cy/ac/ov      ALU outputs to capture
//   wr_acc, wr_b             load ACC / B from alu_result
//   flag_mode                00 none, 01 CY, 10 CY+AC+OV, 11 none
//   psw_we, psw_din          direct PSW write (bit 0 ignored)
//   mul_start, div_start     start MUL AB / DIV AB (MUL wins on a tie)
//   md_busy, md_done         sequencer running / one-cycle completion pulse
//   acc, b_reg, psw, cy, ac  architectural state; psw = {CY,AC,F0,RS1,RS0,OV,F1,P}
module acc_psw_unit #(
  parameter int MD_STEPS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] alu_result,
  input  logic       alu_cy,
  input  logic       alu_ac,
  input  logic       alu_ov,
  input  logic       wr_acc,
  input  logic       wr_b,
  input  logic [1:0] flag_mode,
  input  logic       psw_we,
  input  logic [7:0] psw_din,
  input  logic       mul_start,
  input  logic       div_start,
  output logic       md_busy,
  output logic       md_done,
  output logic [7:0] acc,
  output logic [7:0] b_reg,
  output logic [7:0] psw,
  output logic       cy,
  output logic       ac
);
  localparam int CW = (MD_STEPS > 1) ? $clog2(MD_STEPS) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_acc, r_b;
  logic [7:1]    r_psw;   // P is never stored
  // Shared MUL/DIV datapath: r_hi = product high / partial remainder,
  // r_lo = multiplier-product low / dividend-quotient, r_opd = multiplicand / divisor.
  logic [7:0]    r_hi, r_lo, r_opd;
  logic          r_div;

  logic       w_run, w_mul_go, w_div_go, w_dz, w_start;
  logic [8:0] w_madd, w_dsh;
  logic       w_dge;
  logic [7:0] w_nhi, w_nlo;
  logic       w_unused;

  assign w_unused = psw_din[0];

  assign w_run    = (r_state == S_RUN);
  // DONE behaves as IDLE for commands, so a start in the md_done cycle is taken.
  assign w_mul_go = !w_run && mul_start;
  assign w_div_go = !w_run && div_start && !mul_start;
  assign w_dz     = w_div_go && (r_b == 8'h00);
  assign w_start  = w_mul_go || (w_div_go && !w_dz);

  // MUL step: conditionally add multiplicand to the high half, shift right.
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : 9'd0);
  // DIV step: shift next dividend bit into remainder, subtract if it fits.
  // Remainder stays below divisor, so 8-bit modular subtraction is exact.
  assign w_dsh  = {r_hi, r_lo[7]};
  assign w_dge  = (w_dsh >= {1'b0, r_opd});

  always_comb begin
    w_nhi = w_madd[8:1];
    w_nlo = {w_madd[0], r_lo[7:1]};
    if (r_div) begin
      w_nhi = w_dge ? (w_dsh[7:0] - r_opd) : w_dsh[7:0];
      w_nlo = {r_lo[6:0], w_dge};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= 8'h00;
      r_b     <= 8'h00;
      r_psw   <= 7'h00;
      r_hi    <= 8'h00;
      r_lo    <= 8'h00;
      r_opd   <= 8'h00;
      r_div   <= 1'b0;
    end else if (w_run) begin
      r_hi  <= w_nhi;
      r_lo  <= w_nlo;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(MD_STEPS - 1)) begin
        // Final iteration commits its own next values directly.
        r_acc    <= w_nlo;
        r_b      <= w_nhi;
        r_psw[7] <= 1'b0;
        r_psw[2] <= r_div ? 1'b0 : (w_nhi != 8'h00);
        r_state  <= S_DONE;
      end
    end else begin
      r_state <= S_IDLE;
      if (w_start) begin
        r_hi    <= 8'h00;
        r_lo    <= w_mul_go ? r_b : r_acc;
        r_opd   <= w_mul_go ? r_acc : r_b;
        r_div   <= !w_mul_go;
        r_cnt   <= '0;
        r_state <= S_RUN;
      end else if (w_dz) begin
        r_psw[7] <= 1'b0;
        r_psw[2] <= 1'b1;
        r_state  <= S_DONE;
      end else begin
        if (wr_acc) r_acc <= alu_result;
        if (wr_b)   r_b   <= alu_result;
        if (psw_we) r_psw <= psw_din[7:1];
        // Flag capture is after the PSW write so ALU flags win on collision.
        case (flag_mode)
          2'b01: r_psw[7] <= alu_cy;
          2'b10: begin
            r_psw[7] <= alu_cy;
            r_psw[6] <= alu_ac;
            r_psw[2] <= alu_ov;
          end
          default: ;
        endcase
      end
    end
  end

  assign md_busy = w_run;
  assign md_done = (r_state == S_DONE);
  assign acc     = r_acc;
  assign b_reg   = r_b;
  assign psw     = {r_psw, ^r_acc};
  assign cy      = r_psw[7];
  assign ac      = r_psw[6];
endmodule
